// File: rtl/reset_sequencer_pkg.sv
// Shared encodings and field widths for the staged reset sequencer.
package reset_sequencer_pkg;
    localparam int SEQ_W   = 3;
    localparam int STG_W   = 3;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    typedef enum logic [SEQ_W-1:0] {
        ST_STARTUP = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } seq_state_e;
endpackage

// File: rtl/reset_sequencer_if.sv
// Per-stage reset/start/done bundle between the sequencer and its resources.
interface reset_sequencer_if #(parameter int NSTAGE = 4);
    logic [NSTAGE-1:0] stg_done;
    logic [NSTAGE-1:0] stg_rst;
    logic [NSTAGE-1:0] stg_start;

    modport master (input stg_done, output stg_rst, output stg_start);
    modport slave  (output stg_done, input stg_rst, input stg_start);
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous done/lock inputs.
module reset_sequencer_sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_s1, r_s2;

    always_ff @(posedge i_clk) begin
        r_s1 <= i_d;
        r_s2 <= r_s1;
    end

    assign o_q = r_s2;
endmodule

// File: rtl/reset_sequencer.sv
// Ordered bring-up of NSTAGE resources with timeout/retry, fault hold and
// run-time loss-of-lock re-sequencing from the lowest failed stage.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int               NSTAGE    = 4,
    parameter int               CNT_W     = 20,
    parameter logic [CNT_W-1:0] STRT_DLY  = 20'h7FFFF,
    parameter int               RST_HOLD  = 16,
    parameter int               STABLE    = 64,
    parameter logic [CNT_W-1:0] TMO       = 20'd100000,
    parameter int               MAX_RETRY = 3,
    parameter logic [NSTAGE-1:0] MON_MASK = {NSTAGE{1'b1}}
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_restart,
    reset_sequencer_if.master  io_stg,
    output logic               o_sys_rst,
    output logic               o_run,
    output logic               o_fault,
    output logic [STG_W-1:0]   o_fault_stg,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [LOSS_W-1:0]  o_loss_cnt,
    output logic [SEQ_W-1:0]   o_seq_state
);
    seq_state_e         r_state, w_nstate;
    logic [CNT_W-1:0]   r_cnt, w_cnt, r_stab, w_stab;
    logic [STG_W-1:0]   r_k, w_k, r_fstg, w_fstg, w_lost_idx;
    logic [RETRY_W-1:0] r_retry, w_retry;
    logic [LOSS_W-1:0]  r_loss, w_loss;
    logic [NSTAGE-1:0]  w_done_s, r_stg_rst, w_stg_rst, r_stg_start, w_stg_start;
    logic               r_sys_rst, r_run, r_fault, w_done_k, w_lost;

    reset_sequencer_sync_2ff #(.W(NSTAGE)) u_sync_2ff (
        .i_clk (i_clk),
        .i_d   (io_stg.stg_done),
        .o_q   (w_done_s)
    );

    // Done of the current stage, and lowest monitored stage that lost lock.
    always_comb begin
        w_done_k   = 1'b0;
        w_lost     = 1'b0;
        w_lost_idx = '0;
        for (int i = 0; i < NSTAGE; i++)
            if (r_k == STG_W'(i)) w_done_k = w_done_s[i];
        for (int i = NSTAGE - 1; i >= 0; i--)
            if (MON_MASK[i] && !w_done_s[i]) begin
                w_lost     = 1'b1;
                w_lost_idx = STG_W'(i);
            end
    end

    always_comb begin
        w_nstate = r_state;
        w_cnt    = r_cnt + 1'b1;
        w_k      = r_k;
        w_stab   = r_stab;
        w_retry  = r_retry;
        w_loss   = r_loss;
        w_fstg   = r_fstg;
        case (r_state)
            ST_STARTUP: begin
                if (r_cnt == STRT_DLY - 1'b1) begin
                    w_nstate = ST_ASSERT;
                    w_cnt    = '0;
                    w_k      = '0;
                end
            end
            ST_ASSERT: begin
                if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
                    w_nstate = ST_WAIT;
                    w_cnt    = '0;
                    w_stab   = '0;
                end
            end
            ST_WAIT: begin
                w_stab = w_done_k ? r_stab + 1'b1 : '0;
                // Acceptance is tested first so it wins over a coincident timeout.
                if (w_stab == CNT_W'(STABLE)) begin
                    w_cnt = '0;
                    if (r_k == STG_W'(NSTAGE - 1)) begin
                        w_nstate = ST_RUN;
                    end else begin
                        w_nstate = ST_ASSERT;
                        w_k      = r_k + 1'b1;
                        w_retry  = '0;
                    end
                end else if (r_cnt == TMO - 1'b1) begin
                    w_cnt = '0;
                    if (r_retry < RETRY_W'(MAX_RETRY)) begin
                        w_nstate = ST_ASSERT;
                        w_retry  = r_retry + 1'b1;
                    end else begin
                        w_nstate = ST_FAULT;
                        w_fstg   = r_k;
                    end
                end
            end
            ST_RUN: begin
                w_cnt = '0;
                if (w_lost) begin
                    w_nstate = ST_ASSERT;
                    w_k      = w_lost_idx;
                    w_fstg   = w_lost_idx;
                    w_retry  = '0;
                    if (r_loss != '1) w_loss = r_loss + 1'b1;
                end
            end
            ST_FAULT: w_cnt = '0;
            default: begin
                w_nstate = ST_STARTUP;
                w_cnt    = '0;
            end
        endcase
        if (i_restart) begin
            w_nstate = ST_ASSERT;
            w_cnt    = '0;
            w_k      = '0;
            w_stab   = '0;
            w_retry  = '0;
            w_loss   = r_loss;
            w_fstg   = r_fstg;
        end
    end

    // Outputs are decoded from next-state values and registered with the state.
    always_comb begin
        w_stg_rst   = '0;
        w_stg_start = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            case (w_nstate)
                ST_RUN:   w_stg_rst[i] = 1'b0;
                ST_WAIT:  w_stg_rst[i] = (i > int'(w_k));
                ST_FAULT: w_stg_rst[i] = (i >= int'(w_fstg));
                default:  w_stg_rst[i] = (i >= int'(w_k));
            endcase
            w_stg_start[i] = (r_state == ST_ASSERT) && (w_nstate == ST_WAIT) && (i == int'(r_k));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_STARTUP;
            r_cnt       <= '0;
            r_stab      <= '0;
            r_k         <= '0;
            r_fstg      <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_stg_rst   <= '1;
            r_stg_start <= '0;
            r_sys_rst   <= 1'b1;
            r_run       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_cnt       <= w_cnt;
            r_stab      <= w_stab;
            r_k         <= w_k;
            r_fstg      <= w_fstg;
            r_retry     <= w_retry;
            r_loss      <= w_loss;
            r_stg_rst   <= w_stg_rst;
            r_stg_start <= w_stg_start;
            r_sys_rst   <= (w_nstate != ST_RUN);
            r_run       <= (w_nstate == ST_RUN);
            r_fault     <= (w_nstate == ST_FAULT);
        end
    end

    assign io_stg.stg_rst   = r_stg_rst;
    assign io_stg.stg_start = r_stg_start;
    assign o_sys_rst        = r_sys_rst;
    assign o_run            = r_run;
    assign o_fault          = r_fault;
    assign o_fault_stg      = r_fstg;
    assign o_retry_cnt      = r_retry;
    assign o_loss_cnt       = r_loss;
    assign o_seq_state      = r_state;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench: expectations are queued with their due cycle and checked at negedge.
module tb_reset_sequencer;
    localparam int S_ST = 0, S_RST = 1, S_START = 2, S_SYS = 3, S_RUN = 4;
    localparam int S_FLT = 5, S_FSTG = 6, S_RTY = 7, S_LOSS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       restart;
    logic       sys_rst, run, fault;
    logic [2:0] fault_stg, seq_state;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         t0;
    int         pat[8] = '{0, 0, 1, 1, 0, 1, 1, 1};

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } exp_t;
    exp_t sb_q[$];

    reset_sequencer_if #(.NSTAGE(3)) stg_if ();

    reset_sequencer #(
        .NSTAGE(3), .CNT_W(20), .STRT_DLY(20'd10), .RST_HOLD(4),
        .STABLE(3), .TMO(20'd20), .MAX_RETRY(2), .MON_MASK(3'b111)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_restart   (restart),
        .io_stg      (stg_if),
        .o_sys_rst   (sys_rst),
        .o_run       (run),
        .o_fault     (fault),
        .o_fault_stg (fault_stg),
        .o_retry_cnt (retry_cnt),
        .o_loss_cnt  (loss_cnt),
        .o_seq_state (seq_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs_v, input int exp_v);
        n_chk++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs_v, exp_v);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            S_ST:    return int'(seq_state);
            S_RST:   return int'(stg_if.stg_rst);
            S_START: return int'(stg_if.stg_start);
            S_SYS:   return int'(sys_rst);
            S_RUN:   return int'(run);
            S_FLT:   return int'(fault);
            S_FSTG:  return int'(fault_stg);
            S_RTY:   return int'(retry_cnt);
            S_LOSS:  return int'(loss_cnt);
            default: return -1;
        endcase
    endfunction

    task automatic ex(input int t, input int sel, input int val, input string tag);
        exp_t e;
        int   pos;
        e.cyc = t; e.sel = sel; e.val = val; e.tag = tag;
        pos = sb_q.size();
        for (int j = 0; j < sb_q.size(); j++)
            if (sb_q[j].cyc > t) begin
                pos = j;
                break;
            end
        sb_q.insert(pos, e);
    endtask

    task automatic ex_rst(input int t, input string tag);
        ex(t, S_ST, 0, tag);   ex(t, S_RST, 7, tag);  ex(t, S_START, 0, tag);
        ex(t, S_SYS, 1, tag);  ex(t, S_RUN, 0, tag);  ex(t, S_FLT, 0, tag);
        ex(t, S_FSTG, 0, tag); ex(t, S_RTY, 0, tag);  ex(t, S_LOSS, 0, tag);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            chk($sformatf("%s_sel%0d@%0d", e.tag, e.sel, e.cyc), obs(e.sel), e.val);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        stg_if.stg_done = 3'b111;
        wait_to(3);
        ex_rst(cyc + 1, "reset");
        wait_to(cyc + 2);

        // Clean bring-up with all done inputs held high.
        t0 = cyc;
        rst = 1'b0;
        ex(t0 + 9, S_ST, 0, "s1_startup");    ex(t0 + 10, S_ST, 1, "s1_assert");
        ex(t0 + 10, S_RST, 7, "s1_rst_hold"); ex(t0 + 13, S_RST, 7, "s1_rst0_hi");
        ex(t0 + 14, S_RST, 6, "s1_rst0_lo");  ex(t0 + 14, S_ST, 2, "s1_wait");
        ex(t0 + 14, S_START, 1, "s1_start0"); ex(t0 + 21, S_START, 2, "s1_start1");
        ex(t0 + 28, S_START, 4, "s1_start2"); ex(t0 + 29, S_START, 0, "s1_start_end");
        ex(t0 + 30, S_RUN, 0, "s1_run_pre");  ex(t0 + 30, S_SYS, 1, "s1_sys_pre");
        ex(t0 + 31, S_RUN, 1, "s1_run");      ex(t0 + 31, S_SYS, 0, "s1_sys");
        ex(t0 + 31, S_RST, 0, "s1_rst_run");  ex(t0 + 31, S_ST, 3, "s1_st_run");
        wait_to(t0 + 35);

        // Stage 1 done stuck low: two retries then fault.
        rst = 1'b1;
        stg_if.stg_done = 3'b101;
        step(); step();
        rst = 1'b0;
        t0 = cyc;
        ex(t0 + 30, S_RST, 4, "s2_wait1_rst");
        ex(t0 + 40, S_RTY, 0, "s2_rty0");     ex(t0 + 41, S_RTY, 1, "s2_rty1");
        ex(t0 + 41, S_ST, 1, "s2_reassert");  ex(t0 + 64, S_RTY, 1, "s2_rty1_hold");
        ex(t0 + 65, S_RTY, 2, "s2_rty2");     ex(t0 + 88, S_ST, 2, "s2_last_wait");
        ex(t0 + 89, S_ST, 4, "s2_fault_st");  ex(t0 + 89, S_FLT, 1, "s2_fault");
        ex(t0 + 89, S_FSTG, 1, "s2_fstg");    ex(t0 + 89, S_RST, 6, "s2_fault_rst");
        ex(t0 + 89, S_RTY, 2, "s2_rty_fault"); ex(t0 + 89, S_SYS, 1, "s2_sys");
        ex(t0 + 95, S_ST, 4, "s2_fault_hold");
        wait_to(t0 + 96);

        // Restart out of FAULT, then a glitchy stage 0 done pattern.
        t0 = cyc;
        restart = 1'b1;
        stg_if.stg_done = 3'b000;
        ex(t0 + 1, S_ST, 1, "s3_restart_st"); ex(t0 + 1, S_FLT, 0, "s3_restart_flt");
        ex(t0 + 1, S_RST, 7, "s3_restart_rst"); ex(t0 + 1, S_RTY, 0, "s3_restart_rty");
        ex(t0 + 5, S_START, 1, "s3_start0");
        ex(t0 + 8, S_ST, 2, "s3_no_early");   ex(t0 + 9, S_ST, 2, "s3_stab_clr");
        ex(t0 + 10, S_ST, 2, "s3_still_wait"); ex(t0 + 11, S_ST, 1, "s3_accept");
        ex(t0 + 11, S_RST, 6, "s3_k1_rst");
        ex(t0 + 15, S_START, 2, "s3_start1"); ex(t0 + 22, S_START, 4, "s3_start2");
        ex(t0 + 24, S_RUN, 0, "s3_run_pre");  ex(t0 + 25, S_RUN, 1, "s3_run");
        wait_to(t0 + 1);
        restart = 1'b0;
        for (int j = 0; j < 8; j++) begin
            wait_to(t0 + 1 + j);
            stg_if.stg_done[0] = (pat[j] != 0);
        end
        wait_to(t0 + 11);
        stg_if.stg_done = 3'b111;
        wait_to(t0 + 30);

        // Loss of stage 1 lock while running.
        t0 = cyc;
        stg_if.stg_done = 3'b101;
        ex(t0 + 2, S_RUN, 1, "s4_run_lag");   ex(t0 + 3, S_RUN, 0, "s4_run_drop");
        ex(t0 + 3, S_LOSS, 1, "s4_loss");     ex(t0 + 3, S_FSTG, 1, "s4_fstg");
        ex(t0 + 3, S_RST, 6, "s4_rst");       ex(t0 + 3, S_ST, 1, "s4_assert");
        ex(t0 + 3, S_RTY, 0, "s4_rty");       ex(t0 + 7, S_START, 2, "s4_start1");
        ex(t0 + 10, S_RST, 4, "s4_k2_rst");   ex(t0 + 14, S_START, 4, "s4_start2");
        ex(t0 + 16, S_RUN, 0, "s4_run_pre");  ex(t0 + 17, S_RUN, 1, "s4_run_back");
        ex(t0 + 17, S_LOSS, 1, "s4_loss_hold");
        wait_to(t0 + 5);
        stg_if.stg_done = 3'b111;
        wait_to(t0 + 20);

        // Acceptance coincides with timeout, then reset in mid-WAIT of stage 2.
        t0 = cyc;
        restart = 1'b1;
        stg_if.stg_done = 3'b000;
        ex(t0 + 24, S_ST, 2, "s5_wait_end");  ex(t0 + 25, S_ST, 1, "s5_accept");
        ex(t0 + 25, S_RST, 6, "s5_k1");       ex(t0 + 25, S_RTY, 0, "s5_rty");
        ex(t0 + 36, S_START, 4, "s5_start2"); ex(t0 + 37, S_ST, 2, "s5_mid_wait");
        ex_rst(t0 + 38, "s6_rst");
        ex(t0 + 41, S_ST, 0, "s6_rst_hold");  ex(t0 + 41, S_RST, 7, "s6_rst_hold");
        ex(t0 + 41, S_FLT, 0, "s6_rst_hold"); ex(t0 + 41, S_LOSS, 0, "s6_rst_hold");
        ex(t0 + 43, S_ST, 0, "s6_startup");
        wait_to(t0 + 1);
        restart = 1'b0;
        wait_to(t0 + 20);
        stg_if.stg_done = 3'b111;
        wait_to(t0 + 37);
        rst = 1'b1;
        restart = 1'b1;
        wait_to(t0 + 41);
        rst = 1'b0;
        restart = 1'b0;
        wait_to(t0 + 45);

        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
